mode_scheduler: RTL and testbench

Top-level mode controller that owns the shared buzzer and LED bank. It decides which of the three player blocks (free play, auto play, learn) drives them. A debounced mode button steps through the modes. Each switch inserts a fixed silent gap, during which every player is held in reset, so no stale note or song position leaks across a mode change.

---
 rtl/mode_scheduler.sv | 98 +++++++++
 tb/tb_mode_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mode_scheduler.sv
// mode_scheduler: debounced mode button steps IDLE->FREE->AUTO->LEARN->FREE with a silent,
// player-resetting gap between modes; owns the buzzer/LED output mux.
module mode_scheduler #(
  parameter int         DEBOUNCE_CYCLES = 2_000_000,
  parameter int         GAP_CYCLES      = 10_000_000,
  parameter logic [3:0] REST_NOTE       = 4'd0,
  parameter logic [6:0] LED_OFF         = 7'b0000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic [3:0] free_note,
  input  logic [3:0] auto_note,
  input  logic [3:0] learn_note,
  input  logic [1:0] free_octave,
  input  logic [1:0] auto_octave,
  input  logic [1:0] learn_octave,
  input  logic [6:0] free_led,
  input  logic [6:0] auto_led,
  input  logic [6:0] learn_led,
  output logic [3:0] note_to_play,
  output logic [1:0] octave_out,
  output logic [6:0] led_out,
  output logic [2:0] player_rst_n,
  output logic [2:0] mode_state
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, FREE = 3'd1, AUTO = 3'd2, LEARN = 3'd3, GAP = 3'd4} state_t;
  state_t state, state_nx, next_mode, next_mode_nx;
  logic sync1, sync2, db, press, gap_done, hold;
  logic [DW-1:0] db_cnt;
  logic [GW-1:0] gap_cnt;
  logic [3:0] note_nx;
  logic [1:0] oct_nx;
  logic [6:0] led_nx;
  logic [2:0] rst_nx;
  assign mode_state = state;
  assign gap_done = gap_cnt == GW'(GAP_CYCLES - 1);
  // Counter only runs while the synchronized level disagrees; it saturates because reaching the limit flips db.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db     <= 1'b0;
      press  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= mode_btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES)) begin
        db     <= ~db;
        db_cnt <= '0;
        press  <= ~db;
      end else db_cnt <= db_cnt + 1'b1;
    end
  always_comb begin
    state_nx     = state;
    next_mode_nx = next_mode;
    if (state > GAP) state_nx = IDLE;
    else if (state == GAP) state_nx = gap_done ? next_mode : GAP;
    else if (press) begin
      state_nx     = GAP;
      next_mode_nx = state == FREE ? AUTO : state == AUTO ? LEARN : FREE;
    end
  end
  // Forward player data only once a mode has been held for a full cycle, so entry and exit edges are silent.
  always_comb begin
    hold    = state == state_nx;
    note_nx = !hold ? REST_NOTE : state == FREE ? free_note : state == AUTO ? auto_note :
              state == LEARN ? learn_note : REST_NOTE;
    oct_nx  = !hold ? 2'b00 : state == FREE ? free_octave : state == AUTO ? auto_octave :
              state == LEARN ? learn_octave : 2'b00;
    led_nx  = !hold ? LED_OFF : state == FREE ? free_led : state == AUTO ? auto_led :
              state == LEARN ? learn_led : LED_OFF;
    rst_nx  = state_nx == FREE ? 3'b001 : state_nx == AUTO ? 3'b010 : state_nx == LEARN ? 3'b100 : 3'b000;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      next_mode    <= IDLE;
      gap_cnt      <= '0;
      note_to_play <= REST_NOTE;
      octave_out   <= 2'b00;
      led_out      <= LED_OFF;
      player_rst_n <= 3'b000;
    end else begin
      state        <= state_nx;
      next_mode    <= next_mode_nx;
      gap_cnt      <= state == GAP ? gap_cnt + 1'b1 : '0;
      note_to_play <= note_nx;
      octave_out   <= oct_nx;
      led_out      <= led_nx;
      player_rst_n <= rst_nx;
    end
endmodule

// File: tb/tb_mode_scheduler.sv
// tb_mode_scheduler: table-driven mode walk, hand corner sequences and random stimulus
// against a cycle-level reference model of the scheduler rules.
module tb_mode_scheduler;
  localparam int D = 4;
  localparam int G = 8;
  logic clk = 1'b0, reset = 1'b0, mode_btn = 1'b0;
  logic [3:0] free_note, auto_note, learn_note, note_to_play;
  logic [1:0] free_octave, auto_octave, learn_octave, octave_out;
  logic [6:0] free_led, auto_led, learn_led, led_out;
  logic [2:0] player_rst_n, mode_state;
  int checks = 0, failures = 0;
  int m_s0, m_s1, m_db, m_run, m_press, m_mode, m_next, m_gap;
  int e_ms, e_rst, e_note, e_oct, e_led;
  int gcnt;
  typedef struct {
    logic btn;
    int   cycles;
    int   exp_ms;
    int   exp_rst;
    int   exp_note;
  } step_t;
  step_t steps[8];

  mode_scheduler #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G), .REST_NOTE(4'd0), .LED_OFF(7'b0000000)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn),
    .free_note(free_note), .auto_note(auto_note), .learn_note(learn_note),
    .free_octave(free_octave), .auto_octave(auto_octave), .learn_octave(learn_octave),
    .free_led(free_led), .auto_led(auto_led), .learn_led(learn_led),
    .note_to_play(note_to_play), .octave_out(octave_out), .led_out(led_out),
    .player_rst_n(player_rst_n), .mode_state(mode_state));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_s0 = 0; m_s1 = 0; m_db = 0; m_run = 0; m_press = 0;
    m_mode = 0; m_next = 0; m_gap = 0;
    e_ms = 0; e_rst = 0; e_note = 0; e_oct = 0; e_led = 0;
  endfunction

  function automatic int sel(input int ms, input int f, input int a, input int l);
    return ms == 1 ? f : ms == 2 ? a : ms == 3 ? l : 0;
  endfunction

  // Mode number plus "gap cycles remaining"; a press pulse is seen one edge after the level flips.
  task automatic model_edge();
    int pr, old_ms;
    pr = m_press;
    old_ms = e_ms;
    m_press = 0;
    if (m_s1 == m_db) m_run = 0;
    else if (m_run == D) begin
      m_db = 1 - m_db;
      m_run = 0;
      m_press = m_db;
    end else m_run++;
    m_s1 = m_s0;
    m_s0 = int'(mode_btn);
    if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) m_mode = m_next;
    end else if (pr != 0) begin
      m_next = m_mode % 3 + 1;
      m_gap = G;
    end
    e_ms  = m_gap > 0 ? 4 : m_mode;
    e_rst = (e_ms >= 1 && e_ms <= 3) ? (1 << (e_ms - 1)) : 0;
    e_note = e_ms == old_ms ? sel(e_ms, free_note, auto_note, learn_note) : 0;
    e_oct  = e_ms == old_ms ? sel(e_ms, free_octave, auto_octave, learn_octave) : 0;
    e_led  = e_ms == old_ms ? sel(e_ms, free_led, auto_led, learn_led) : 0;
  endtask

  task automatic check_model();
    chk("mode_state", mode_state, e_ms);
    chk("player_rst_n", player_rst_n, e_rst);
    chk("note_to_play", note_to_play, e_note);
    chk("octave_out", octave_out, e_oct);
    chk("led_out", led_out, e_led);
  endtask

  task automatic cycle(input logic b, input bit rnd);
    @(negedge clk);
    mode_btn = b;
    if (rnd) begin
      free_note = 4'($urandom); auto_note = 4'($urandom); learn_note = 4'($urandom);
      free_octave = 2'($urandom); auto_octave = 2'($urandom); learn_octave = 2'($urandom);
      free_led = 7'($urandom); auto_led = 7'($urandom); learn_led = 7'($urandom);
    end
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    check_model();
    if (mode_state == 3'd4) gcnt++;
  endtask

  task automatic hold_btn(input logic b, input int n);
    for (int k = 0; k < n; k++) cycle(b, 1'b0);
  endtask

  initial begin
    steps[0] = '{1'b1, 10, 4, 0, 0};
    steps[1] = '{1'b0, 20, 1, 1, 5};
    steps[2] = '{1'b1, 10, 4, 0, 0};
    steps[3] = '{1'b0, 20, 2, 2, 3};
    steps[4] = '{1'b1, 10, 4, 0, 0};
    steps[5] = '{1'b0, 20, 3, 4, 7};
    steps[6] = '{1'b1, 10, 4, 0, 0};
    steps[7] = '{1'b0, 20, 1, 1, 5};
    free_note = 4'd5; free_octave = 2'd2; free_led = 7'h15;
    auto_note = 4'd3; auto_octave = 2'd1; auto_led = 7'h2a;
    learn_note = 4'd7; learn_octave = 2'd3; learn_led = 7'h7f;
    model_reset();
    // Reset held with the button pressed: everything stays silent and idle.
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b0);
      chk("rst_mode_state", mode_state, 0);
      chk("rst_player_rst_n", player_rst_n, 0);
      chk("rst_note", note_to_play, 0);
      chk("rst_led", led_out, 0);
    end
    @(negedge clk);
    mode_btn = 1'b0;
    reset = 1'b1;
    hold_btn(1'b0, 5);
    chk("idle_after_release", mode_state, 0);
    // Full mode walk with wrap; every gap must be exactly G cycles.
    gcnt = 0;
    for (int i = 0; i < 8; i++) begin
      hold_btn(steps[i].btn, steps[i].cycles);
      chk("step_mode_state", mode_state, steps[i].exp_ms);
      chk("step_player_rst_n", player_rst_n, steps[i].exp_rst);
      chk("step_note", note_to_play, steps[i].exp_note);
      if (i % 2 == 1) begin
        chk("gap_len", gcnt, G);
        gcnt = 0;
      end
    end
    chk("free_octave_fwd", octave_out, 2);
    // Bounce in FREE: toggles every 2 cycles never reach the debounce count.
    for (int k = 0; k < 10; k++) hold_btn(k % 2 == 0, 2);
    hold_btn(1'b0, 10);
    chk("bounce_stays_free", mode_state, 1);
    // Button activity during GAP: one advance only, gap still G cycles.
    gcnt = 0;
    hold_btn(1'b1, 8);
    chk("gap_entered", mode_state, 4);
    for (int k = 0; k < 4; k++) hold_btn(k % 2 == 1, 3);
    hold_btn(1'b0, 20);
    chk("gap_press_len", gcnt, G);
    chk("gap_press_one_advance", mode_state, 2);
    chk("auto_isolation", note_to_play, 3);
    // AUTO -> LEARN: silence, then learn data.
    hold_btn(1'b1, 10);
    chk("learn_gap_note", note_to_play, 0);
    hold_btn(1'b0, 20);
    chk("learn_note", note_to_play, 7);
    chk("learn_rst", player_rst_n, 3'b100);
    // Reset asserted asynchronously on the 4th GAP cycle.
    hold_btn(1'b1, 11);
    chk("mid_gap", mode_state, 4);
    @(negedge clk);
    reset = 1'b0;
    mode_btn = 1'b0;
    model_reset();
    #1;
    chk("async_mode_state", mode_state, 0);
    chk("async_player_rst_n", player_rst_n, 0);
    chk("async_note", note_to_play, 0);
    chk("async_octave", octave_out, 0);
    chk("async_led", led_out, 0);
    hold_btn(1'b0, 3);
    @(negedge clk);
    reset = 1'b1;
    hold_btn(1'b0, 3);
    hold_btn(1'b1, 10);
    hold_btn(1'b0, 20);
    chk("after_reset_free", mode_state, 1);
    chk("after_reset_rst", player_rst_n, 3'b001);
    // Random button segments and player data against the model.
    for (int s = 0; s < 60; s++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom);
      len = int'($urandom_range(1, 14));
      for (int k = 0; k < len; k++) cycle(lvl, 1'b1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
